// File: rtl/seven_seg_scanner.sv
// rtl/seven_seg_scanner.sv - four-digit active-low 7-segment multiplexer with frame-coherent latching and dead-time.
// Optional leading-zero blanking of digit 3: SEVEN_SEG_LEADING_ZERO_BLANK_EN.
module seven_seg_scanner #(
   parameter int PRESCALE    = 4,
   parameter int DEAD_CYCLES = 1
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [6:0] i_hex0,
   input  logic [6:0] i_hex1,
   input  logic [6:0] i_hex2,
   input  logic [6:0] i_hex3,
   output logic [6:0] o_seg,
   output logic [3:0] o_an,
   output logic       o_frame_start
);

   localparam int CW = $clog2(PRESCALE);

   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    idx_q, idx_d;
   logic [6:0]    shadow_q [4];
   logic [6:0]    shadow_d [4];
   logic [6:0]    seg_q, seg_d;
   logic [3:0]    an_q, an_d;
   logic          fs_q, fs_d;
   logic          load;
   logic          hide_slot;

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
   logic          blank3_q, blank3_d;
`endif

   always_comb begin
      load  = (idx_q == 2'd0) && (cnt_q == '0);
      cnt_d = cnt_q + CW'(1);
      idx_d = idx_q;
      if (cnt_q == CW'(PRESCALE - 1)) begin
         cnt_d = '0;
         idx_d = idx_q + 2'd1;
      end

      // On the load edge the freshly latched values double as the bypass source.
      shadow_d = shadow_q;
      if (load) begin
         shadow_d[0] = i_hex0;
         shadow_d[1] = i_hex1;
         shadow_d[2] = i_hex2;
         shadow_d[3] = i_hex3;
      end

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
      blank3_d  = load ? (i_hex3 == 7'b1000000) : blank3_q;
      hide_slot = (idx_q == 2'd3) && blank3_q;
`else
      hide_slot = 1'b0;
`endif

      fs_d  = load;
      an_d  = 4'b1111;
      seg_d = 7'b1111111;
      if (!(int'(cnt_q) < DEAD_CYCLES) && !hide_slot) begin
         an_d[idx_q] = 1'b0;
         seg_d       = shadow_d[idx_q];
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         cnt_q    <= '0;
         idx_q    <= 2'd0;
         shadow_q <= '{default: 7'b1111111};
         seg_q    <= 7'b1111111;
         an_q     <= 4'b1111;
         fs_q     <= 1'b0;
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
         blank3_q <= 1'b0;
`endif
      end else begin
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         shadow_q <= shadow_d;
         seg_q    <= seg_d;
         an_q     <= an_d;
         fs_q     <= fs_d;
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
         blank3_q <= blank3_d;
`endif
      end
   end

   assign o_seg         = seg_q;
   assign o_an          = an_q;
   assign o_frame_start = fs_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb/tb_seven_seg_scanner.sv - self-checking bench for seven_seg_scanner (4/1 and 2/0 configurations).
module tb_seven_seg_scanner;

   logic       clk = 1'b0;
   logic       rst;
   logic [6:0] h0, h1, h2, h3;
   logic [6:0] seg_a, seg_b;
   logic [3:0] an_a, an_b;
   logic       fs_a, fs_b;

   always #5 clk = ~clk;

   seven_seg_scanner #(.PRESCALE(4), .DEAD_CYCLES(1)) dut_a (
      .i_clk(clk), .i_rst(rst), .i_hex0(h0), .i_hex1(h1), .i_hex2(h2), .i_hex3(h3),
      .o_seg(seg_a), .o_an(an_a), .o_frame_start(fs_a)
   );

   seven_seg_scanner #(.PRESCALE(2), .DEAD_CYCLES(0)) dut_b (
      .i_clk(clk), .i_rst(rst), .i_hex0(h0), .i_hex1(h1), .i_hex2(h2), .i_hex3(h3),
      .o_seg(seg_b), .o_an(an_b), .o_frame_start(fs_b)
   );

   int vectors = 0;
   int miscompares = 0;

   // Reference model: edge count since reset release and the frame's latched digits.
   int         n_m [2];
   int         pre_m [2]  = '{4, 2};
   int         dead_m [2] = '{1, 0};
   logic [6:0] sh_m [2][4];
   logic [3:0] exp_an [2];
   logic [6:0] exp_seg [2];
   logic       exp_fs [2];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model(input int w);
      int  pos, slot, c;
      bit  blank;
      if (rst) begin
         n_m[w] = 0;
         for (int k = 0; k < 4; k++) sh_m[w][k] = 7'b1111111;
         exp_an[w]  = 4'b1111;
         exp_seg[w] = 7'b1111111;
         exp_fs[w]  = 1'b0;
      end else begin
         n_m[w]++;
         pos = (n_m[w] - 1) % (4 * pre_m[w]);
         if (pos == 0) begin
            sh_m[w][0] = h0; sh_m[w][1] = h1; sh_m[w][2] = h2; sh_m[w][3] = h3;
         end
         slot  = pos / pre_m[w];
         c     = pos % pre_m[w];
         blank = (c < dead_m[w]);
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
         if (slot == 3 && sh_m[w][3] == 7'b1000000) blank = 1'b1;
`endif
         exp_fs[w]  = (pos == 0);
         exp_an[w]  = blank ? 4'b1111 : ~(4'b0001 << slot);
         exp_seg[w] = blank ? 7'b1111111 : sh_m[w][slot];
      end
   endtask

   task automatic tick();
      model(0);
      model(1);
      @(posedge clk);
      #1;
      check("a_an",  32'(an_a),  32'(exp_an[0]));
      check("a_seg", 32'(seg_a), 32'(exp_seg[0]));
      check("a_fs",  32'(fs_a),  32'(exp_fs[0]));
      check("b_an",  32'(an_b),  32'(exp_an[1]));
      check("b_seg", 32'(seg_b), 32'(exp_seg[1]));
      check("b_fs",  32'(fs_b),  32'(exp_fs[1]));
      if (!rst) check("b_onehot", 32'($countones(~an_b)), 32'd1);
   endtask

   task automatic set_hex(input logic [6:0] a, input logic [6:0] b, input logic [6:0] c, input logic [6:0] d);
      h0 = a; h1 = b; h2 = c; h3 = d;
   endtask

   initial begin
      rst = 1'b1;
      set_hex(7'($urandom), 7'($urandom), 7'($urandom), 7'($urandom));
      repeat (3) tick();

      rst = 1'b0;
      set_hex(7'b0110000, 7'b0100100, 7'b0010010, 7'b1111001);
      tick();
      check("e1_fs", 32'(fs_a), 32'd1);
      check("e1_an", 32'(an_a), 32'hf);
      tick();
      check("e2_an",  32'(an_a),  32'b1110);
      check("e2_seg", 32'(seg_a), 32'b0110000);
      repeat (3) tick();
      set_hex(7'b0001110, 7'b0001110, 7'b0001110, 7'b0001110);
      repeat (9) tick();
      check("e14_an",  32'(an_a),  32'b0111);
      check("e14_seg", 32'(seg_a), 32'b1111001);
      repeat (4) tick();
      check("e18_seg", 32'(seg_a), 32'b0001110);
      repeat (14) tick();

      set_hex(7'b0110000, 7'b0100100, 7'b0010010, 7'b1000000);
      repeat (16) tick();
      check("lz_an", 32'(an_a), 32'b0111 |
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
         32'b1000
`else
         32'b0000
`endif
      );

      while (n_m[0] % 16 != 8) tick();
      rst = 1'b1;
      tick();
      check("mr_an",  32'(an_a),  32'hf);
      check("mr_seg", 32'(seg_a), 32'h7f);
      rst = 1'b0;
      set_hex(7'b0000001, 7'b0000010, 7'b0000100, 7'b0001000);
      tick();
      check("mr_fs", 32'(fs_a), 32'd1);
      tick();
      check("mr_seg0", 32'(seg_a), 32'b0000001);

      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 2) == 0)
            set_hex(7'($urandom), 7'($urandom), 7'($urandom),
                    ($urandom_range(0, 3) == 0) ? 7'b1000000 : 7'($urandom));
         rst = ($urandom_range(0, 49) == 0);
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
